tex_req_arbiter: RTL

- Shares one texture unit request/response port among NUM_REQS requesters (e.g. per-core sockets feeding a shared tex unit).
- Round-robin arbitration with per-requester credit limiting.
- Registered request output stage; requester index is appended to the tag so responses route back.
- Sits between requester tex buses and the texture unit top-level request/response ports.

---
 rtl/tex_req_arbiter_if.sv | 62 ++++++
 rtl/tex_req_arbiter.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/tex_req_arbiter_if.sv
// Requester-side and texture-unit-side buses of tex_req_arbiter, bundled in one interface.
// The arbiter uses the slave modport; the surrounding requesters and tex unit use master.
interface tex_req_arbiter_if #(
    parameter int unsigned NUM_REQS   = 4,
    parameter int unsigned NUM_LANES  = 4,
    parameter int unsigned TAG_WIDTH  = 8,
    parameter int unsigned LOD_BITS   = 4,
    parameter int unsigned STAGE_BITS = 1
);
    localparam int unsigned SEL_BITS   = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;
    localparam int unsigned OTAG_WIDTH = TAG_WIDTH + SEL_BITS;

    // Requester side, flattened per requester
    logic [NUM_REQS-1:0]                    in_req_valid;
    logic [NUM_REQS*NUM_LANES-1:0]          in_req_mask;
    logic [NUM_REQS*2*NUM_LANES*32-1:0]     in_req_coords;
    logic [NUM_REQS*NUM_LANES*LOD_BITS-1:0] in_req_lod;
    logic [NUM_REQS*STAGE_BITS-1:0]         in_req_stage;
    logic [NUM_REQS*TAG_WIDTH-1:0]          in_req_tag;
    logic [NUM_REQS-1:0]                    in_req_ready;
    logic [NUM_REQS-1:0]                    in_rsp_valid;
    logic [NUM_REQS*NUM_LANES*32-1:0]       in_rsp_texels;
    logic [NUM_REQS*TAG_WIDTH-1:0]          in_rsp_tag;
    logic [NUM_REQS-1:0]                    in_rsp_ready;

    // Texture unit side
    logic                                   tex_req_valid;
    logic [NUM_LANES-1:0]                   tex_req_mask;
    logic [2*NUM_LANES*32-1:0]              tex_req_coords;
    logic [NUM_LANES*LOD_BITS-1:0]          tex_req_lod;
    logic [STAGE_BITS-1:0]                  tex_req_stage;
    logic [OTAG_WIDTH-1:0]                  tex_req_tag;
    logic                                   tex_req_ready;
    logic                                   tex_rsp_valid;
    logic [NUM_LANES*32-1:0]                tex_rsp_texels;
    logic [OTAG_WIDTH-1:0]                  tex_rsp_tag;
    logic                                   tex_rsp_ready;

    modport master (
        output in_req_valid, in_req_mask, in_req_coords, in_req_lod, in_req_stage, in_req_tag,
        input  in_req_ready,
        input  in_rsp_valid, in_rsp_texels, in_rsp_tag,
        output in_rsp_ready,
        input  tex_req_valid, tex_req_mask, tex_req_coords, tex_req_lod, tex_req_stage,
        input  tex_req_tag,
        output tex_req_ready,
        output tex_rsp_valid, tex_rsp_texels, tex_rsp_tag,
        input  tex_rsp_ready
    );

    modport slave (
        input  in_req_valid, in_req_mask, in_req_coords, in_req_lod, in_req_stage, in_req_tag,
        output in_req_ready,
        output in_rsp_valid, in_rsp_texels, in_rsp_tag,
        input  in_rsp_ready,
        output tex_req_valid, tex_req_mask, tex_req_coords, tex_req_lod, tex_req_stage,
        output tex_req_tag,
        input  tex_req_ready,
        input  tex_rsp_valid, tex_rsp_texels, tex_rsp_tag,
        output tex_rsp_ready
    );
endinterface

// File: rtl/tex_req_arbiter.sv
// Round-robin, credit-limited arbiter sharing one texture unit port among NUM_REQS requesters.
// Requests go through one output register; the requester index rides in the tag LSBs.
module tex_req_arbiter #(
    parameter int unsigned NUM_REQS    = 4,
    parameter int unsigned NUM_LANES   = 4,
    parameter int unsigned TAG_WIDTH   = 8,
    parameter int unsigned LOD_BITS    = 4,
    parameter int unsigned STAGE_BITS  = 1,
    parameter int unsigned MAX_PENDING = 4
) (
    input logic             clk,
    input logic             reset,
    tex_req_arbiter_if.slave bus
);
    localparam int unsigned SEL_BITS   = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;
    localparam int unsigned OTAG_WIDTH = TAG_WIDTH + SEL_BITS;
    localparam int unsigned CNT_BITS   = $clog2(MAX_PENDING + 1);
    localparam int unsigned COORD_BITS = 2 * NUM_LANES * 32;
    localparam int unsigned LODV_BITS  = NUM_LANES * LOD_BITS;
    localparam logic [CNT_BITS-1:0] PEND_MAX = CNT_BITS'(MAX_PENDING);

    // Output register
    logic                  out_valid_q;
    logic [NUM_LANES-1:0]  out_mask_q;
    logic [COORD_BITS-1:0] out_coords_q;
    logic [LODV_BITS-1:0]  out_lod_q;
    logic [STAGE_BITS-1:0] out_stage_q;
    logic [OTAG_WIDTH-1:0] out_tag_q;

    logic [SEL_BITS-1:0]               rr_ptr_q, rr_ptr_d;
    logic [NUM_REQS-1:0][CNT_BITS-1:0] pend_q, pend_d;

    logic [NUM_REQS-1:0]   elig, grant, pend_inc, pend_dec;
    logic [SEL_BITS-1:0]   grant_idx;
    logic                  grant_any, load, accept;

    logic [NUM_LANES-1:0]  sel_mask;
    logic [COORD_BITS-1:0] sel_coords;
    logic [LODV_BITS-1:0]  sel_lod;
    logic [STAGE_BITS-1:0] sel_stage;
    logic [TAG_WIDTH-1:0]  sel_tag;

    logic [SEL_BITS-1:0]   rsp_sel;
    logic [NUM_REQS-1:0]   rsp_hit;
    logic                  rsp_sel_ok;

    // Grant: first eligible requester at or after rr_ptr, wrapping.
    always_comb begin
        elig      = '0;
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        for (int unsigned i = 0; i < NUM_REQS; i++) begin
            elig[i] = bus.in_req_valid[i] && (pend_q[i] < PEND_MAX);
        end
        for (int unsigned k = 0; k < NUM_REQS; k++) begin
            for (int unsigned i = 0; i < NUM_REQS; i++) begin
                if (!grant_any && elig[i] && (i == (32'(rr_ptr_q) + k) % NUM_REQS)) begin
                    grant_any = 1'b1;
                    grant[i]  = 1'b1;
                    grant_idx = SEL_BITS'(i);
                end
            end
        end
    end

    assign load   = ~out_valid_q | bus.tex_req_ready;
    assign accept = grant_any & load & ~reset;

    assign bus.in_req_ready = grant & {NUM_REQS{load & ~reset}};

    always_comb begin
        sel_mask   = '0;
        sel_coords = '0;
        sel_lod    = '0;
        sel_stage  = '0;
        sel_tag    = '0;
        for (int unsigned i = 0; i < NUM_REQS; i++) begin
            if (grant[i]) begin
                sel_mask   = bus.in_req_mask[i*NUM_LANES +: NUM_LANES];
                sel_coords = bus.in_req_coords[i*COORD_BITS +: COORD_BITS];
                sel_lod    = bus.in_req_lod[i*LODV_BITS +: LODV_BITS];
                sel_stage  = bus.in_req_stage[i*STAGE_BITS +: STAGE_BITS];
                sel_tag    = bus.in_req_tag[i*TAG_WIDTH +: TAG_WIDTH];
            end
        end
    end

    assign rr_ptr_d = accept ? SEL_BITS'((32'(grant_idx) + 1) % NUM_REQS) : rr_ptr_q;

    // Response routing: the index in the tag LSBs picks the requester; no storage.
    assign rsp_sel = bus.tex_rsp_tag[SEL_BITS-1:0];

    always_comb begin
        rsp_hit = '0;
        for (int unsigned i = 0; i < NUM_REQS; i++) begin
            rsp_hit[i] = (rsp_sel == SEL_BITS'(i));
        end
    end

    assign rsp_sel_ok        = |rsp_hit;
    assign bus.in_rsp_valid  = {NUM_REQS{bus.tex_rsp_valid}} & rsp_hit;
    // Out-of-range index: nobody can take it, so it is accepted and dropped.
    assign bus.tex_rsp_ready = rsp_sel_ok ? |(bus.in_rsp_ready & rsp_hit) : 1'b1;
    assign bus.in_rsp_texels = {NUM_REQS{bus.tex_rsp_texels}};
    assign bus.in_rsp_tag    = {NUM_REQS{bus.tex_rsp_tag[OTAG_WIDTH-1:SEL_BITS]}};

    assign pend_inc = grant & {NUM_REQS{accept}};
    assign pend_dec = bus.in_rsp_valid & bus.in_rsp_ready;

    always_comb begin
        pend_d = pend_q;
        for (int unsigned i = 0; i < NUM_REQS; i++) begin
            if (pend_inc[i] && !pend_dec[i]) begin
                pend_d[i] = pend_q[i] + CNT_BITS'(1);
            end else if (pend_dec[i] && !pend_inc[i] && (pend_q[i] != '0)) begin
                pend_d[i] = pend_q[i] - CNT_BITS'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            rr_ptr_q    <= '0;
            pend_q      <= '0;
        end else begin
            if (load) begin
                out_valid_q <= grant_any;
            end
            rr_ptr_q <= rr_ptr_d;
            pend_q   <= pend_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            out_mask_q   <= sel_mask;
            out_coords_q <= sel_coords;
            out_lod_q    <= sel_lod;
            out_stage_q  <= sel_stage;
            out_tag_q    <= {sel_tag, grant_idx};
        end
    end

    assign bus.tex_req_valid  = out_valid_q;
    assign bus.tex_req_mask   = out_mask_q;
    assign bus.tex_req_coords = out_coords_q;
    assign bus.tex_req_lod    = out_lod_q;
    assign bus.tex_req_stage  = out_stage_q;
    assign bus.tex_req_tag    = out_tag_q;

    rsp_sel_range: assert property (@(posedge clk) disable iff (reset)
        bus.tex_rsp_valid |-> rsp_sel_ok)
        else $error("tex_req_arbiter: response index out of range, dropped");

    for (genvar g = 0; g < NUM_REQS; g++) begin : g_pend_chk
        pend_underflow: assert property (@(posedge clk) disable iff (reset)
            !(pend_dec[g] && !pend_inc[g] && (pend_q[g] == '0)))
            else $error("tex_req_arbiter: response to requester %0d with nothing pending", g);
    end

endmodule
